alu_operand_sequencer: RTL and testbench
========================================

// Module: alu_operand_sequencer
// PURPOSE
//  Upstream stage of the 10-bit signed ALU, which is combinational and has no clock.
//  - Collects arg0, arg1 and opcode from one shared data bus (board switches), one per enter press.
//  - Drives the ALU from registered outputs.
//  - Registers the ALU result and flags, then offers them downstream on a valid/ready handshake.
//  - Keeps a saturating count of overflow results.
// PARAMETERS
//  W            10  operand/result width (two's complement)
//  OPW          3   opcode width
//  SYNC_STAGES  2   synchronizer flops on i_enter (>=2)
//  CNT_W        8   overflow counter width
// PORTS
//  i_clk       in   1      single clock, all flops rising edge
//  i_rst_n     in   1      reset: asynchronous, active-low
//  i_data      in   W      shared entry bus: arg0, arg1, or opcode in [OPW-1:0]
//  i_enter     in   1      asynchronous push-button, level
//  i_abort     in   1      synchronous abort, level, clk domain
//  o_arg0      out  W      registered ALU operand 0
//  o_arg1      out  W      registered ALU operand 1
//  o_oper      out  OPW    registered ALU opcode
//  i_result    in   W      ALU result (combinational from o_arg*/o_oper)
//  i_flag      in   4      ALU flags {NEG,POS,ZERO,OVF}; bit0 = OVF
//  o_result_q  out  W      captured result
//  o_flag_q    out  4      captured flags
//  o_valid     out  1      captured result available downstream
//  i_ready     in   1      downstream accepts
//  o_err       out  1      1-cycle pulse: illegal opcode entered
//  o_state     out  3      current FSM state encoding
//  o_ovf_cnt   out  CNT_W  saturating count of OVF results
// BEHAVIOUR
//  - Reset: state=S_A. All outputs are 0: o_arg0, o_arg1, o_oper, o_result_q, o_flag_q, o_valid, o_err, o_ovf_cnt. The sync chain is cleared.
//  - i_enter passes through SYNC_STAGES flops and a rising-edge detect, giving enter_p.
//  - enter_p is one cycle long and appears SYNC_STAGES+1 cycles after the i_enter rise.
//  - Holding i_enter high produces exactly one enter_p.
//  - FSM encoding: S_A=0, S_B=1, S_OP=2, S_EXEC=3, S_OUT=4. Codes 5..7 are unreachable and go to S_A.
//  - S_A: on enter_p, o_arg0<=i_data, go to S_B.
//  - S_B: on enter_p, o_arg1<=i_data, go to S_OP.
//  - S_OP: on enter_p, test i_data[OPW-1:0] (upper bits ignored).
//    - Value <=6 (ADD..XNOR): o_oper<=value, go to S_EXEC.
//    - Value 7: o_err=1 for one cycle, o_oper unchanged, stay in S_OP.
//  - S_EXEC: lasts exactly 1 cycle, long enough for the ALU to settle on the registered inputs.
//    - o_result_q<=i_result and o_flag_q<=i_flag.
//    - If i_flag[0]=1, o_ovf_cnt increments, saturating at 2^CNT_W-1.
//    - o_valid<=1, go to S_OUT.
//  - Latency: 2 cycles from the opcode enter_p to o_valid=1.
//  - S_OUT: o_valid is held high; o_result_q and o_flag_q are held stable.
//    - On o_valid&&i_ready: o_valid<=0, go to S_A. Transfer is 1 cycle if i_ready is already high.
//    - enter_p is ignored (dropped) in S_OUT and S_EXEC.
//  - i_abort has highest priority in every state:
//    - next state S_A, o_valid<=0, and no counter increment.
//    - o_arg*, o_oper and o_result_q keep their values.
//    - An enter_p in the same cycle is dropped.
//  - Abort during S_EXEC discards that capture: o_result_q, o_flag_q and o_ovf_cnt are unchanged.
//  - Asserting reset in any state returns all state to the reset values within the same cycle, asynchronously.
//  - No arithmetic is done here. Widths pass straight through, and i_result is never sign-extended or truncated.
// STRUCTURE
//  - Shared package alu_pkg holds:
//    - opcode constants ADD=0, SUB=1, SHIFT=2, AND=3, ORR=4, XOR=5, XNOR=6, and OP_MAX=6;
//    - flag bit indices F_NEG=3, F_POS=2, F_ZERO=1, F_OVF=0;
//    - the state typedef/constants S_A..S_OUT.
//  - Sub-module btn_sync_edge (SYNC_STAGES): synchronizer plus rising-edge pulse, reused for other buttons.
//  - Top-level: FSM, operand/opcode registers, result capture and overflow counter.
// TESTING
//  1. Enter 3, -5 (0x3FB), opcode 0, i_ready=1 -> o_result_q=0x3FE (-2), o_flag_q=4'b1000; o_valid high 1 cycle.
//  2. Enter 300, 300, ADD -> o_result_q=-424 (0x258), o_flag_q=4'b1001, o_ovf_cnt=1.
//  3. In S_OP enter 7 -> o_err 1-cycle pulse, o_state stays 2. Then enter 1 -> SUB proceeds.
//  4. Hold i_ready=0 for 20 cycles in S_OUT and press enter -> o_valid and o_result_q stable, state stays 4. Raise i_ready -> S_A.
//  5. Abort in S_B, and separately abort on the same cycle as the opcode enter_p -> S_A next cycle, o_valid=0, counter unchanged.
//  6. Force 2^CNT_W+3 overflowing ops -> o_ovf_cnt saturates at 255. Assert reset mid-S_EXEC -> all outputs 0, o_state=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, flag bit positions, sequencer state codes.
package alu_pkg;

  localparam logic [2:0] ADD    = 3'd0;
  localparam logic [2:0] SUB    = 3'd1;
  localparam logic [2:0] SHIFT  = 3'd2;
  localparam logic [2:0] AND    = 3'd3;
  localparam logic [2:0] ORR    = 3'd4;
  localparam logic [2:0] XOR    = 3'd5;
  localparam logic [2:0] XNOR   = 3'd6;
  localparam logic [2:0] OP_MAX = 3'd6;

  localparam int F_NEG  = 3;
  localparam int F_POS  = 2;
  localparam int F_ZERO = 1;
  localparam int F_OVF  = 0;

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_OP   = 3'd2,
    S_EXEC = 3'd3,
    S_OUT  = 3'd4
  } state_t;

endpackage

// File: rtl/btn_sync_edge.sv
// Button synchronizer plus registered rising-edge detect: one pulse per press,
// SYNC_STAGES+1 cycles after the button rises.
module btn_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_pulse
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   r_pulse;

  // Shift the raw level into the clock domain, then flag the 0->1 transition.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync  <= '0;
      r_prev  <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], i_btn};
      r_prev  <= r_sync[SYNC_STAGES-1];
      r_pulse <= r_sync[SYNC_STAGES-1] & ~r_prev;
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/alu_operand_sequencer.sv
// Operand/opcode entry sequencer in front of a combinational ALU: gathers
// arg0, arg1 and opcode from one bus, captures the ALU result and offers it
// downstream on valid/ready, and counts overflow results.
import alu_pkg::*;

module alu_operand_sequencer #(
  parameter int W           = 10,
  parameter int OPW         = 3,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [W-1:0]     i_data,
  input  logic             i_enter,
  input  logic             i_abort,
  output logic [W-1:0]     o_arg0,
  output logic [W-1:0]     o_arg1,
  output logic [OPW-1:0]   o_oper,
  input  logic [W-1:0]     i_result,
  input  logic [3:0]       i_flag,
  output logic [W-1:0]     o_result_q,
  output logic [3:0]       o_flag_q,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_err,
  output logic [2:0]       o_state,
  output logic [CNT_W-1:0] o_ovf_cnt
);

  state_t           r_state, w_state_nxt;
  logic             w_enter_p;
  logic [OPW-1:0]   w_op;
  logic             w_op_legal;
  logic             w_ld_arg0, w_ld_arg1, w_ld_oper, w_bad_op, w_capture;
  logic [W-1:0]     r_arg0, r_arg1, r_result_q;
  logic [OPW-1:0]   r_oper;
  logic [3:0]       r_flag_q;
  logic             r_valid, r_err;
  logic [CNT_W-1:0] r_ovf_cnt;

  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_enter_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_btn   (i_enter),
    .o_pulse (w_enter_p)
  );

  assign w_op       = i_data[OPW-1:0];
  assign w_op_legal = (w_op <= OPW'(OP_MAX));

  // Abort wins everywhere, so every load strobe is qualified by !i_abort.
  assign w_ld_arg0 = !i_abort && w_enter_p && (r_state == S_A);
  assign w_ld_arg1 = !i_abort && w_enter_p && (r_state == S_B);
  assign w_ld_oper = !i_abort && w_enter_p && (r_state == S_OP) && w_op_legal;
  assign w_bad_op  = !i_abort && w_enter_p && (r_state == S_OP) && !w_op_legal;
  assign w_capture = !i_abort && (r_state == S_EXEC);

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_A;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic; enter pulses outside A/B/OP fall through unused.
  always_comb begin
    w_state_nxt = r_state;
    if (i_abort) begin
      w_state_nxt = S_A;
    end else begin
      case (r_state)
        S_A:     if (w_enter_p) w_state_nxt = S_B;
        S_B:     if (w_enter_p) w_state_nxt = S_OP;
        S_OP:    if (w_enter_p && w_op_legal) w_state_nxt = S_EXEC;
        S_EXEC:  w_state_nxt = S_OUT;
        S_OUT:   if (i_ready) w_state_nxt = S_A;
        default: w_state_nxt = S_A;
      endcase
    end
  end

  // Operand/opcode registers, result capture, overflow counter, handshake.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_arg0     <= '0;
      r_arg1     <= '0;
      r_oper     <= '0;
      r_result_q <= '0;
      r_flag_q   <= '0;
      r_valid    <= 1'b0;
      r_err      <= 1'b0;
      r_ovf_cnt  <= '0;
    end else begin
      if (w_ld_arg0) r_arg0 <= i_data;
      if (w_ld_arg1) r_arg1 <= i_data;
      if (w_ld_oper) r_oper <= w_op;
      r_err <= w_bad_op;
      if (w_capture) begin
        r_result_q <= i_result;
        r_flag_q   <= i_flag;
        if (i_flag[F_OVF] && (r_ovf_cnt != {CNT_W{1'b1}}))
          r_ovf_cnt <= r_ovf_cnt + CNT_W'(1);
      end
      // Valid is simply "we will be in S_OUT": set from EXEC, held while
      // stalled, dropped on transfer or abort.
      r_valid <= (w_state_nxt == S_OUT);
    end
  end

  assign o_arg0     = r_arg0;
  assign o_arg1     = r_arg1;
  assign o_oper     = r_oper;
  assign o_result_q = r_result_q;
  assign o_flag_q   = r_flag_q;
  assign o_valid    = r_valid;
  assign o_err      = r_err;
  assign o_state    = r_state;
  assign o_ovf_cnt  = r_ovf_cnt;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Bench for alu_operand_sequencer: a behavioural ALU closes the loop, and
// expected results are queued on opcode entry and checked on o_valid.
module tb_alu_operand_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] i_data;
  logic       i_enter, i_abort, i_ready;
  logic [9:0] o_arg0, o_arg1, i_result, o_result_q;
  logic [2:0] o_oper, o_state;
  logic [3:0] i_flag, o_flag_q;
  logic       o_valid, o_err;
  logic [7:0] o_ovf_cnt;
  logic [13:0] alu_out;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_cnt = 0;
  logic [13:0] exp_q[$];

  always #5 clk = ~clk;

  alu_operand_sequencer #(.W(10), .OPW(3), .SYNC_STAGES(2), .CNT_W(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(i_data), .i_enter(i_enter),
    .i_abort(i_abort), .o_arg0(o_arg0), .o_arg1(o_arg1), .o_oper(o_oper),
    .i_result(i_result), .i_flag(i_flag), .o_result_q(o_result_q),
    .o_flag_q(o_flag_q), .o_valid(o_valid), .i_ready(i_ready), .o_err(o_err),
    .o_state(o_state), .o_ovf_cnt(o_ovf_cnt)
  );

  // Reference 10-bit signed ALU: returns {result, NEG, POS, ZERO, OVF}.
  function automatic logic [13:0] alu_m(input logic [9:0] a, input logic [9:0] b,
                                        input logic [2:0] op);
    logic [9:0] r;
    logic       ovf;
    ovf = 1'b0;
    case (op)
      3'd0: begin r = a + b; ovf = (a[9] == b[9]) && (r[9] != a[9]); end
      3'd1: begin r = a - b; ovf = (a[9] != b[9]) && (r[9] != a[9]); end
      3'd2: r = a << 1;
      3'd3: r = a & b;
      3'd4: r = a | b;
      3'd5: r = a ^ b;
      3'd6: r = ~(a ^ b);
      default: r = '0;
    endcase
    return {r, r[9], (!r[9] && (r != 0)), (r == 0), ovf};
  endfunction

  always_comb alu_out = alu_m(o_arg0, o_arg1, o_oper);
  assign i_result = alu_out[13:4];
  assign i_flag   = alu_out[3:0];

  task automatic press(input logic [9:0] d);
    @(negedge clk);
    i_data  = d;
    i_enter = 1'b1;
    repeat (6) @(negedge clk);
    i_enter = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // Full transaction; the opcode press waits (bounded) for o_valid.
  task automatic run_op(input logic [9:0] a, input logic [9:0] b, input logic [2:0] op);
    logic [13:0] e;
    bit          seen;
    press(a);
    n_tests++;
    if (o_state !== 3'd1 || o_arg0 !== a) begin
      n_fail++; $display("FAIL arg0_load: state=%0d arg0=%h, want 1 / %h", o_state, o_arg0, a);
    end
    press(b);
    n_tests++;
    if (o_state !== 3'd2 || o_arg1 !== b) begin
      n_fail++; $display("FAIL arg1_load: state=%0d arg1=%h, want 2 / %h", o_state, o_arg1, b);
    end
    e = alu_m(a, b, op);
    exp_q.push_back(e);
    if (e[0] && exp_cnt != 255) exp_cnt++;
    seen = 0;
    @(negedge clk);
    i_data  = {7'd0, op};
    i_enter = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 5) i_enter = 1'b0;
      if (o_valid) begin seen = 1; break; end
    end
    i_enter = 1'b0;
    n_tests++;
    if (!seen) begin
      n_fail++; $display("FAIL valid_timeout: o_valid=0 after 20 cycles, want 1");
      void'(exp_q.pop_front());
    end else if (exp_q.size() == 0) begin
      n_fail++; $display("FAIL scoreboard_empty: result=%h with nothing expected", o_result_q);
    end else begin
      e = exp_q.pop_front();
      if (o_result_q !== e[13:4] || o_flag_q !== e[3:0]) begin
        n_fail++; $display("FAIL result: got %h/%b, want %h/%b", o_result_q, o_flag_q, e[13:4], e[3:0]);
      end
    end
    n_tests++;
    if (o_ovf_cnt !== 8'(exp_cnt)) begin
      n_fail++; $display("FAIL ovf_cnt: got %0d, want %0d", o_ovf_cnt, exp_cnt);
    end
    if (i_ready) begin
      @(negedge clk);
      n_tests++;
      if (o_valid !== 1'b0 || o_state !== 3'd0) begin
        n_fail++; $display("FAIL transfer: valid=%b state=%0d, want 0/0", o_valid, o_state);
      end
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset;
    n_tests++;
    if ({o_arg0, o_arg1, o_oper, o_result_q, o_flag_q, o_valid, o_err, o_ovf_cnt, o_state} !== '0) begin
      n_fail++; $display("FAIL reset_state: outputs %h %h %h %h %b %b %b %h st=%0d, want all 0",
                         o_arg0, o_arg1, o_oper, o_result_q, o_flag_q, o_valid, o_err, o_ovf_cnt, o_state);
    end
  endtask

  task automatic test_basic;
    i_ready = 1'b1;
    run_op(10'd3, 10'h3FB, 3'd0);
    n_tests++;
    if (o_result_q !== 10'h3FE || o_flag_q !== 4'b1000) begin
      n_fail++; $display("FAIL basic_add: got %h/%b, want 3fe/1000", o_result_q, o_flag_q);
    end
  endtask

  task automatic test_overflow;
    run_op(10'd300, 10'd300, 3'd0);
    n_tests++;
    if (o_result_q !== 10'h258 || o_flag_q !== 4'b1001 || o_ovf_cnt !== 8'd1) begin
      n_fail++; $display("FAIL ovf_add: got %h/%b cnt=%0d, want 258/1001 cnt=1", o_result_q, o_flag_q, o_ovf_cnt);
    end
  endtask

  task automatic test_illegal_op;
    logic [2:0] saved_op;
    int         errs;
    errs = 0;
    press(10'd5);
    press(10'd6);
    saved_op = o_oper;
    @(negedge clk);
    i_data  = 10'h3C7;   // upper bits set; low 3 bits = 7
    i_enter = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 5) i_enter = 1'b0;
      if (o_err) errs++;
    end
    n_tests++;
    if (errs != 1 || o_state !== 3'd2 || o_oper !== saved_op) begin
      n_fail++; $display("FAIL illegal_op: err_cycles=%0d state=%0d oper=%0d, want 1/2/%0d", errs, o_state, o_oper, saved_op);
    end
    exp_q.push_back(alu_m(10'd5, 10'd6, 3'd1));
    @(negedge clk);
    i_data  = 10'd1;
    i_enter = 1'b1;
    errs = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 5) i_enter = 1'b0;
      if (o_valid) begin errs = 1; break; end
    end
    i_enter = 1'b0;
    n_tests++;
    if (errs == 0) begin
      n_fail++; $display("FAIL sub_after_err: o_valid never rose, want 1");
      void'(exp_q.pop_front());
    end else begin
      logic [13:0] e;
      e = exp_q.pop_front();
      if (o_result_q !== e[13:4] || o_flag_q !== e[3:0] || o_oper !== 3'd1) begin
        n_fail++; $display("FAIL sub_after_err: got %h/%b op=%0d, want %h/%b op=1", o_result_q, o_flag_q, o_oper, e[13:4], e[3:0]);
      end
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_back_pressure;
    logic [9:0] held;
    int         bad;
    bad = 0;
    i_ready = 1'b0;
    run_op(10'd100, 10'd23, 3'd0);
    held = o_result_q;
    i_data = 10'd77;
    for (int i = 0; i < 20; i++) begin
      if (i == 4)  i_enter = 1'b1;
      if (i == 10) i_enter = 1'b0;
      @(negedge clk);
      if (o_valid !== 1'b1 || o_result_q !== held || o_state !== 3'd4) bad++;
    end
    n_tests++;
    if (bad != 0 || held !== 10'd123 || o_arg0 !== 10'd100) begin
      n_fail++; $display("FAIL stall: bad_cycles=%0d result=%0d arg0=%0d, want 0/123/100", bad, held, o_arg0);
    end
    i_ready = 1'b1;
    @(negedge clk);
    n_tests++;
    if (o_valid !== 1'b0 || o_state !== 3'd0) begin
      n_fail++; $display("FAIL stall_release: valid=%b state=%0d, want 0/0", o_valid, o_state);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_abort;
    logic [2:0] saved_op;
    logic [9:0] saved_res;
    press(10'd11);
    @(negedge clk);
    i_abort = 1'b1;
    @(negedge clk);
    i_abort = 1'b0;
    n_tests++;
    if (o_state !== 3'd0 || o_valid !== 1'b0 || o_arg0 !== 10'd11) begin
      n_fail++; $display("FAIL abort_b: state=%0d valid=%b arg0=%0d, want 0/0/11", o_state, o_valid, o_arg0);
    end
    press(10'd22);
    press(10'd33);
    saved_op  = o_oper;
    saved_res = o_result_q;
    @(negedge clk);
    i_data  = 10'd6;
    i_enter = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if (o_state !== 3'd2) begin
      n_fail++; $display("FAIL abort_pre: state=%0d, want 2", o_state);
    end
    i_abort = 1'b1;        // lands on the edge that consumes the opcode pulse
    @(negedge clk);
    i_abort = 1'b0;
    n_tests++;
    if (o_state !== 3'd0 || o_valid !== 1'b0 || o_oper !== saved_op || o_ovf_cnt !== 8'(exp_cnt)) begin
      n_fail++; $display("FAIL abort_op: state=%0d valid=%b oper=%0d cnt=%0d, want 0/0/%0d/%0d",
                         o_state, o_valid, o_oper, o_ovf_cnt, saved_op, exp_cnt);
    end
    repeat (3) @(negedge clk);
    i_enter = 1'b0;
    repeat (5) @(negedge clk);
    n_tests++;
    if (o_state !== 3'd0 || o_valid !== 1'b0 || o_result_q !== saved_res || o_arg0 !== 10'd22) begin
      n_fail++; $display("FAIL abort_after: state=%0d valid=%b res=%h arg0=%0d, want 0/0/%h/22",
                         o_state, o_valid, o_result_q, saved_res, o_arg0);
    end
  endtask

  task automatic test_saturate_and_reset;
    bit hit;
    hit = 0;
    i_ready = 1'b1;
    for (int k = 0; k < 259; k++) run_op(10'd300, 10'd300, 3'd0);
    n_tests++;
    if (o_ovf_cnt !== 8'd255) begin
      n_fail++; $display("FAIL saturate: cnt=%0d, want 255", o_ovf_cnt);
    end
    press(10'd1);
    press(10'd2);
    @(negedge clk);
    i_data  = 10'd0;
    i_enter = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (o_state === 3'd3) begin hit = 1; break; end
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (!hit || {o_arg0, o_arg1, o_oper, o_result_q, o_flag_q, o_valid, o_err, o_ovf_cnt, o_state} !== '0) begin
      n_fail++; $display("FAIL reset_exec: hit=%b state=%0d cnt=%0d res=%h valid=%b, want exec hit and all 0",
                         hit, o_state, o_ovf_cnt, o_result_q, o_valid);
    end
    exp_q.delete();
    i_enter = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    n_tests++;
    if (o_state !== 3'd0 || o_valid !== 1'b0) begin
      n_fail++; $display("FAIL post_reset: state=%0d valid=%b, want 0/0", o_state, o_valid);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    i_data  = '0;
    i_enter = 1'b0;
    i_abort = 1'b0;
    i_ready = 1'b1;
    repeat (3) @(negedge clk);
    test_reset;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    test_reset;
    test_basic;
    test_overflow;
    test_illegal_op;
    test_back_pressure;
    test_abort;
    test_saturate_and_reset;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
